// File: rtl/counter_pkg.sv
// Shared constants for the free-running counter.
//   COUNTER_DEFAULT_WIDTH : width used when N is not overridden
//   COUNTER_MIN_WIDTH     : smallest legal N
//   COUNTER_MAX_WIDTH     : largest legal N
package counter_pkg;

  localparam int unsigned COUNTER_DEFAULT_WIDTH = 4;
  localparam int unsigned COUNTER_MIN_WIDTH     = 1;
  localparam int unsigned COUNTER_MAX_WIDTH     = 64;

endpackage : counter_pkg

// File: rtl/counter_if.sv
// Bundle carrying the counter value from the counter to its consumers.
//   cnt : current count, N bits
// Modports:
//   master : the counter side, drives cnt
//   slave  : a consumer, samples cnt
interface counter_if
  import counter_pkg::*;
#(
  parameter int unsigned N = COUNTER_DEFAULT_WIDTH
);

  logic [N-1:0] cnt;

  modport master (output cnt);
  modport slave  (input  cnt);

endinterface : counter_if

// File: rtl/counter.sv
// Free-running N-bit binary up-counter with asynchronous active-low reset.
// Increments by one on every rising clock edge while out of reset and wraps
// modulo 2^N. No enable, load or direction control.
// Ports:
//   clock   : sole clock, rising edge active
//   reset_n : asynchronous active-low reset, clears the count immediately
//   cnt     : current count, driven straight from the state register
module counter
  import counter_pkg::*;
#(
  parameter int unsigned N = COUNTER_DEFAULT_WIDTH
) (
  input  logic         clock,
  input  logic         reset_n,
  output logic [N-1:0] cnt
);

  if ((N < COUNTER_MIN_WIDTH) || (N > COUNTER_MAX_WIDTH)) begin : g_bad_width
    $error("counter: N=%0d outside legal range %0d..%0d",
           N, COUNTER_MIN_WIDTH, COUNTER_MAX_WIDTH);
  end

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  // Sum is kept to N bits so the all-ones value rolls over to zero.
  always_comb begin
    cnt_d = cnt_q + N'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : counter

// File: tb/tb_counter.sv
// Self-checking bench for counter at widths 4, 1 and 8 sharing one clock
// and reset. Expected values come from a hand-written vector table and from
// a model that counts rising edges since the last reset and reduces the
// result modulo 2^N.
module tb_counter;

  logic clock;
  logic reset_n;

  counter_if #(.N(4)) if4 ();
  counter_if #(.N(1)) if1 ();
  counter_if #(.N(8)) if8 ();

  counter #(.N(4)) u_dut4 (.clock(clock), .reset_n(reset_n), .cnt(if4.cnt));
  counter #(.N(1)) u_dut1 (.clock(clock), .reset_n(reset_n), .cnt(if1.cnt));
  counter #(.N(8)) u_dut8 (.clock(clock), .reset_n(reset_n), .cnt(if8.cnt));

  // 10 ns period, rising edges at 5, 15, 25 ...; falling edges at 10, 20 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Model state: rising edges seen since reset was last deasserted.
  longint unsigned edges = 0;

  typedef struct {
    logic       rst_v;
    logic [3:0] exp4;
    logic       exp1;
    logic [7:0] exp8;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input int unsigned n);
    longint unsigned m;
    m = longint'(1) << n;
    return 64'(edges % m);
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_n4"}, 64'(if4.cnt), model(4));
    check({tag, "_n1"}, 64'(if1.cnt), model(1));
    check({tag, "_n8"}, 64'(if8.cnt), model(8));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_n4"}, 64'(if4.cnt), 64'd0);
    check({tag, "_n1"}, 64'(if1.cnt), 64'd0);
    check({tag, "_n8"}, 64'(if8.cnt), 64'd0);
  endtask

  // Starts at falling edge + 1 ns, drives reset, waits one full cycle
  // (one rising edge), updates the model, checks, returns at falling + 1 ns.
  task automatic cycle(input logic rst_v, input string tag);
    reset_n = rst_v;
    @(negedge clock);
    edges = rst_v ? edges + 1 : 0;
    check_all(tag);
    #1;
  endtask

  // Asynchronous assertion between edges, observed before the next rising edge.
  task automatic async_reset(input int unsigned delay_ns, input string tag);
    #(delay_ns);
    reset_n = 1'b0;
    edges   = 0;
    #1;
    check_zero({tag, "_imm"});
    @(negedge clock);
    check_zero({tag, "_hold"});
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    // rst_v is applied 1 ns after a falling edge; expectations hold at the
    // following falling edge.
    vecs[0] = '{1'b1, 4'd1, 1'b1, 8'd1};
    vecs[1] = '{1'b1, 4'd2, 1'b0, 8'd2};
    vecs[2] = '{1'b1, 4'd3, 1'b1, 8'd3};
    vecs[3] = '{1'b1, 4'd4, 1'b0, 8'd4};
    vecs[4] = '{1'b0, 4'd0, 1'b0, 8'd0};
    vecs[5] = '{1'b0, 4'd0, 1'b0, 8'd0};
    vecs[6] = '{1'b1, 4'd1, 1'b1, 8'd1};
    vecs[7] = '{1'b1, 4'd2, 1'b0, 8'd2};

    // Reset held from time zero.
    reset_n = 1'b0;
    #1;
    check_zero("reset_t1");
    @(negedge clock);
    check_zero("reset_held_a");
    @(negedge clock);
    check_zero("reset_held_b");
    #1;  // t = 21 ns: first table row releases reset here

    for (int i = 0; i < 8; i++) begin
      reset_n = vecs[i].rst_v;
      @(negedge clock);
      edges = vecs[i].rst_v ? edges + 1 : 0;
      check($sformatf("vec%0d_n4", i), 64'(if4.cnt), 64'(vecs[i].exp4));
      check($sformatf("vec%0d_n1", i), 64'(if1.cnt), 64'(vecs[i].exp1));
      check($sformatf("vec%0d_n8", i), 64'(if8.cnt), 64'(vecs[i].exp8));
      #1;
    end

    // Run past the 4-bit wrap (15 -> 0 -> 1) against the model.
    for (int i = 0; i < 25; i++) cycle(1'b1, "wrap4");

    // Mid-count asynchronous reset, held for 50 ns.
    check("midcount_nonzero", 64'(if4.cnt != 4'd0), 64'd1);
    #2;
    reset_n = 1'b0;
    edges   = 0;
    #1;
    check_zero("midrst_imm");
    #50;
    check_zero("midrst_50ns");

    // Restart: release between edges, expect 1, 2, 3.
    @(negedge clock);
    #1;
    cycle(1'b1, "restart1");
    check("restart1_explicit", 64'(if4.cnt), 64'd1);
    cycle(1'b1, "restart2");
    cycle(1'b1, "restart3");
    check("restart3_explicit", 64'(if4.cnt), 64'd3);

    // Long run through the 8-bit wrap (255 -> 0).
    for (int i = 0; i < 260; i++) cycle(1'b1, "wrap8");

    // Randomized reset activity against the model.
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 47);
      if (r == 0) begin
        cycle(1'b0, "rand_rst");
      end else if (r == 1) begin
        async_reset($urandom_range(1, 2), "rand_async");
      end else begin
        cycle(1'b1, "rand_cnt");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop should the stimulus ever stall.
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_counter

// File: doc/counter.md
Name: counter

Overview:
- Free-running N-bit binary up-counter with asynchronous active-low reset.
- Leaf block used as a time base, cycle stamp or sequence generator. It has no enable, load or direction control.
- Increments by one on every rising clock edge while out of reset and wraps modulo 2^N.

Parameters:
- N, default 4, counter width in bits. Legal range is 1 to 64; an elaboration-time check rejects values outside it.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset. Assertion clears state immediately, independent of the clock.
- cnt  output  N  current count, driven directly from the state register (registered output, no combinational path from any input except the asynchronous reset).

Behaviour:
- Reset:
  - While reset_n = 0, cnt = 0, regardless of clock activity.
  - Assertion takes effect without waiting for a clock edge; cnt is 0 within the same simulation time step as the falling edge of reset_n.
- Counting:
  - On each rising edge of clock with reset_n = 1, cnt <= cnt + 1, computed in N bits.
- Release latency:
  - Release reset_n between clock edges; the first rising edge after release loads cnt = 1.
  - Each subsequent edge adds 1, e.g. 0 -> 1 -> 2 -> 3.
- Wrap-around:
  - At cnt = 2^N - 1, the next edge yields 0; no carry or flag output.
  - For N = 4: 15 -> 0.
- Reset mid-count:
  - Asserting reset_n at any count value forces cnt = 0 at once.
  - cnt stays 0 for all edges while reset is held.
  - Counting resumes from 0 per the release-latency rule above.
- Reset release coincident with a rising clock edge:
  - The count is not required to increment on that edge.
  - The integration requirement is that reset_n is released synchronously (via the system reset synchroniser) away from the active edge.
- No X propagation: after the first reset assertion, cnt is never X/Z.
- N = 1: cnt toggles 0, 1, 0, ... every edge.

Decomposition:
- Shared package counter_pkg holds:
  - constant COUNTER_DEFAULT_WIDTH = 4;
  - constants COUNTER_MIN_WIDTH = 1 and COUNTER_MAX_WIDTH = 64, used by the parameter check.
- No sub-module: a single sequential process with asynchronous reset holds the state register, plus the output assignment.

Test Plan:
- Reset at start: hold reset_n = 0 from t = 0, check 1 ns later -> cnt = 0; after several clock edges with reset still low -> cnt = 0.
- Release and count (N = 4, 10 ns clock period, check on falling edges):
  - release reset_n at t = 21 ns;
  - next three falling edges -> cnt = 1, 2, 3.
- Wrap: continue counting 20+ more cycles (N = 4) -> cnt sequence reaches 15, then 0, then 1; full sequence checked against a modulo-16 reference model every cycle.
- Asynchronous reset mid-count:
  - drive reset_n = 0 between edges at a nonzero count;
  - check immediately (same time step + 1 ns) -> cnt = 0;
  - check 50 ns later -> still 0.
- Restart after mid-count reset: release reset_n -> first rising edge gives cnt = 1, then increments normally.
- Width variants: N = 1 -> toggles 0/1 every edge; N = 8 -> 255 wraps to 0. Both checked against the reference model.
